sdi_rx_scan_ctrl: RTL and testbench
===================================

Name: sdi_rx_scan_ctrl

Overview:
Rate-scan sequencer for the SDI receive core. It drives the receiver's rx_rate scan control {3G, HD, SD} and a SERDES rate select/reset. It steps through the enabled standards until the core reports locked video, then supervises that lock and re-scans on loss. It sits between host configuration and the sdi_core rx_rate input, in the rx_clk domain.

Parameters:
pcntwidth, 20, width of dwell/loss counters
pdwell_cycles, 600000, cycles allowed per rate before advancing (must fit pcntwidth)
prst_cycles, 16, SERDES reset hold after every rate change (>=1)
plock_cycles, 8, consecutive qualified cycles required to declare lock (>=1)
ploss_cycles, 4096, consecutive vid_active-low cycles in LOCKED that declare loss (>=1)

Ports:
rx_clk  in  1  sole clock
rstn  in  1  synchronous active-low reset
scan_mask  in  3  enabled rates {3G,HD,SD}
force_en  in  1  1 = fixed rate, no scanning
force_rate  in  3  fixed rate, one-hot {3G,HD,SD}
vid_active  in  1  from sdi_core
rx_tg_hdn  in  1  from sdi_core
rx_hd_sdn  in  1  from sdi_core
rx_rate  out  3  to sdi_core, one-hot or 000
serdes_rate_sel  out  2  10=3G, 01=HD, 00=SD
serdes_rst  out  1  SERDES rx reset request, active high
locked  out  1  qualified lock
rate_change  out  1  1-cycle pulse when rx_rate loads
unlock_evt  out  1  1-cycle pulse on loss of lock
scan_cnt  out  8  dwell timeouts since last lock, saturating at 255

Behaviour:
- Clock and reset: single clock rx_clk. Reset rstn is synchronous and active-low. All state and outputs update on the rx_clk rising edge.
- Reset values: state INIT, rx_rate=000, serdes_rate_sel=00, serdes_rst=1, locked=0, rate_change=0, unlock_evt=0, scan_cnt=0, counters=0.
- Config: cfg = {force_en, force_rate, scan_mask}, registered every cycle. A change in cfg from any state except INIT forces SEL in search-from-top mode on the next cycle. This also clears locked; unlock_evt is not pulsed.
- Qualified cycle: vid_active=1 and the reported standard matches rx_rate. Match rules: 3G needs rx_tg_hdn=1. HD needs rx_tg_hdn=0 and rx_hd_sdn=1. SD needs rx_tg_hdn=0 and rx_hd_sdn=0.
- INIT: go to SEL in search-from-top mode.
- SEL (1 cycle):
  - Force mode: target is force_rate. If force_rate is not one-hot, go to HOLD.
  - Scan, search-from-top: first enabled bit in order 3G, HD, SD.
  - Scan, advance: next enabled bit after the current rate, in cyclic order 3G→HD→SD→3G. A single enabled rate selects itself.
  - Scan, retry: current rate if still enabled, else search-from-top.
  - scan_mask=000 in scan mode: go to HOLD.
  - On a valid target: load rx_rate and serdes_rate_sel, pulse rate_change (even if the value is unchanged), clear counters, go to RSTS.
- RSTS: serdes_rst=1 for exactly prst_cycles cycles, then go to DWELL with counters cleared. serdes_rst=0 in every other state except HOLD and INIT.
- DWELL:
  - Dwell counter increments every cycle.
  - Lock counter increments on each qualified cycle and clears on any non-qualified cycle.
  - Lock counter reaching plock_cycles: go to LOCKED, locked=1 from the next cycle, scan_cnt cleared.
  - Dwell counter reaching pdwell_cycles-1 without lock: scan_cnt+1 (saturating), then SEL in advance mode (retry mode when force_en=1).
  - If lock and timeout occur in the same cycle, lock wins.
- LOCKED:
  - Loss counter counts consecutive cycles with vid_active=0 and clears when vid_active=1.
  - Standard mismatch while vid_active=1 is ignored here; the core's own lock governs.
  - Loss counter reaching ploss_cycles: locked=0, unlock_evt pulse, SEL in retry mode.
- HOLD: rx_rate=000, serdes_rst=1, locked=0. Stays until cfg changes.
- Latency: first rate_change is 2 cycles after rstn deasserts (INIT, then SEL). rx_rate is stable from rate_change until the next SEL.
- Reset mid-operation: returns immediately to the reset values, whatever the current state.

Test Plan:
- Bench parameters: pdwell=100, prst=4, plock=8, ploss=16.
- mask=111, vid_active stuck 0 → rx_rate sequence 100→010→001→100, 101 cycles apart, serdes_rst high 4 cycles after each rate_change, scan_cnt=3 after the third timeout.
- mask=111, core reports HD (tg_hdn=0, hd_sdn=1, vid_active=1) once rx_rate=010 → locked after 8 qualified cycles, scan_cnt=0, no further rate_change.
- Locked at HD, vid_active low 15 cycles then high → stays locked. Low 16 cycles → unlock_evt pulse, rate_change with rx_rate still 010.
- force_en=1, force_rate=001, no video → rx_rate held at 001, rate_change every 101 cycles. force_rate=011 → HOLD, rx_rate=000, serdes_rst=1.
- mask changes 111→001 while locked at 3G → locked drops with no unlock_evt, next SEL gives rx_rate=001. mask=000 → HOLD.
- rstn low for 1 cycle during RSTS → all outputs at reset values, rate_change 2 cycles after rstn returns high.

Source files
------------

// File: rtl/sdi_rx_scan_ctrl_if.sv
// Signal bundle between the SDI rx rate-scan sequencer, host configuration and sdi_core.
// state_dbg mirrors the sequencer FSM state so checkers can bind to it directly.
interface sdi_rx_scan_ctrl_if;
   logic [2:0] scan_mask;
   logic       force_en;
   logic [2:0] force_rate;
   logic       vid_active;
   logic       rx_tg_hdn;
   logic       rx_hd_sdn;
   logic [2:0] rx_rate;
   logic [1:0] serdes_rate_sel;
   logic       serdes_rst;
   logic       locked;
   logic       rate_change;
   logic       unlock_evt;
   logic [7:0] scan_cnt;
   logic [2:0] state_dbg;

   modport master (
      output scan_mask, force_en, force_rate, vid_active, rx_tg_hdn, rx_hd_sdn,
      input  rx_rate, serdes_rate_sel, serdes_rst, locked, rate_change, unlock_evt,
             scan_cnt, state_dbg
   );

   modport slave (
      input  scan_mask, force_en, force_rate, vid_active, rx_tg_hdn, rx_hd_sdn,
      output rx_rate, serdes_rate_sel, serdes_rst, locked, rate_change, unlock_evt,
             scan_cnt, state_dbg
   );
endinterface

// File: rtl/sdi_rx_scan_ctrl.sv
// Rate-scan sequencer: steps rx_rate through the enabled SDI standards until the core
// reports qualified video, supervises that lock and re-scans when video is lost.
module sdi_rx_scan_ctrl #(
   parameter int pcntwidth     = 20,
   parameter int pdwell_cycles = 600000,
   parameter int prst_cycles   = 16,
   parameter int plock_cycles  = 8,
   parameter int ploss_cycles  = 4096
) (
   input  logic                 rx_clk,
   input  logic                 rstn,
   sdi_rx_scan_ctrl_if.slave    bus
);

   typedef enum logic [2:0] {S_INIT, S_SEL, S_RSTS, S_DWELL, S_LOCKED, S_HOLD} state_t;
   typedef enum logic [1:0] {M_TOP, M_ADV, M_RETRY} mode_t;

   localparam logic [pcntwidth-1:0] dwell_last = pcntwidth'(pdwell_cycles - 1);
   localparam logic [pcntwidth-1:0] rst_last   = pcntwidth'(prst_cycles - 1);
   localparam logic [pcntwidth-1:0] lock_last  = pcntwidth'(plock_cycles - 1);
   localparam logic [pcntwidth-1:0] loss_last  = pcntwidth'(ploss_cycles - 1);

   state_t               state_q, state_d;
   mode_t                mode_q, mode_d;
   logic [6:0]           cfg_q;
   logic [pcntwidth-1:0] dwell_q, dwell_d, lcnt_q, lcnt_d;
   logic [2:0]           rx_rate_q, rx_rate_d;
   logic [1:0]           rate_sel_q, rate_sel_d;
   logic                 serdes_rst_q, serdes_rst_d;
   logic                 locked_q, locked_d;
   logic                 rate_change_q, rate_change_d;
   logic                 unlock_q, unlock_d;
   logic [7:0]           scan_cnt_q, scan_cnt_d;

   logic [6:0] cfg;
   logic       cfg_chg, match, qual, hold_tgt;
   logic [2:0] target, mask_q, frate_q;
   logic       fen_q;

   function automatic logic [2:0] top_of(input logic [2:0] m);
      if (m[2])      return 3'b100;
      else if (m[1]) return 3'b010;
      else if (m[0]) return 3'b001;
      else           return 3'b000;
   endfunction

   // Cyclic order 3G -> HD -> SD -> 3G; the current rate is the last resort.
   function automatic logic [2:0] next_after(input logic [2:0] cur, input logic [2:0] m);
      case (cur)
         3'b100:  return m[1] ? 3'b010 : (m[0] ? 3'b001 : 3'b100);
         3'b010:  return m[0] ? 3'b001 : (m[2] ? 3'b100 : 3'b010);
         3'b001:  return m[2] ? 3'b100 : (m[1] ? 3'b010 : 3'b001);
         default: return top_of(m);
      endcase
   endfunction

   function automatic logic [1:0] sel_of(input logic [2:0] r);
      if (r == 3'b100)      return 2'b10;
      else if (r == 3'b010) return 2'b01;
      else                  return 2'b00;
   endfunction

   assign cfg     = {bus.force_en, bus.force_rate, bus.scan_mask};
   assign cfg_chg = (cfg != cfg_q);
   assign fen_q   = cfg_q[6];
   assign frate_q = cfg_q[5:3];
   assign mask_q  = cfg_q[2:0];

   always_comb begin
      match = 1'b0;
      case (rx_rate_q)
         3'b100:  match = bus.rx_tg_hdn;
         3'b010:  match = !bus.rx_tg_hdn && bus.rx_hd_sdn;
         3'b001:  match = !bus.rx_tg_hdn && !bus.rx_hd_sdn;
         default: match = 1'b0;
      endcase
   end
   assign qual = bus.vid_active && match;

   always_comb begin
      target   = 3'b000;
      hold_tgt = 1'b0;
      if (fen_q) begin
         target   = frate_q;
         hold_tgt = !(frate_q == 3'b100 || frate_q == 3'b010 || frate_q == 3'b001);
      end else if (mask_q == 3'b000) begin
         hold_tgt = 1'b1;
      end else begin
         case (mode_q)
            M_ADV:   target = next_after(rx_rate_q, mask_q);
            M_RETRY: target = |(rx_rate_q & mask_q) ? rx_rate_q : top_of(mask_q);
            default: target = top_of(mask_q);
         endcase
      end
   end

   always_comb begin
      state_d       = state_q;
      mode_d        = mode_q;
      dwell_d       = dwell_q;
      lcnt_d        = lcnt_q;
      rx_rate_d     = rx_rate_q;
      rate_sel_d    = rate_sel_q;
      locked_d      = locked_q;
      rate_change_d = 1'b0;
      unlock_d      = 1'b0;
      scan_cnt_d    = scan_cnt_q;
      case (state_q)
         S_INIT: begin
            state_d = S_SEL;
            mode_d  = M_TOP;
         end
         S_SEL: begin
            if (hold_tgt) begin
               state_d   = S_HOLD;
               rx_rate_d = 3'b000;
               locked_d  = 1'b0;
            end else begin
               state_d       = S_RSTS;
               rx_rate_d     = target;
               rate_sel_d    = sel_of(target);
               rate_change_d = 1'b1;
               dwell_d       = '0;
               lcnt_d        = '0;
            end
         end
         // The dwell window runs from the rate change, so SERDES reset time counts against it.
         S_RSTS: begin
            dwell_d = dwell_q + 1'b1;
            if (dwell_q >= rst_last) begin
               state_d = S_DWELL;
               lcnt_d  = '0;
            end
         end
         S_DWELL: begin
            dwell_d = dwell_q + 1'b1;
            lcnt_d  = qual ? lcnt_q + 1'b1 : '0;
            if (qual && lcnt_q == lock_last) begin
               state_d    = S_LOCKED;
               locked_d   = 1'b1;
               scan_cnt_d = 8'd0;
               lcnt_d     = '0;
            end else if (dwell_q >= dwell_last) begin
               state_d    = S_SEL;
               mode_d     = fen_q ? M_RETRY : M_ADV;
               scan_cnt_d = (scan_cnt_q == 8'hff) ? scan_cnt_q : scan_cnt_q + 8'd1;
            end
         end
         S_LOCKED: begin
            lcnt_d = bus.vid_active ? '0 : lcnt_q + 1'b1;
            if (!bus.vid_active && lcnt_q == loss_last) begin
               state_d  = S_SEL;
               mode_d   = M_RETRY;
               locked_d = 1'b0;
               unlock_d = 1'b1;
            end
         end
         default: ;
      endcase
      // A configuration edit restarts the search silently from the top.
      if (cfg_chg && state_q != S_INIT) begin
         state_d       = S_SEL;
         mode_d        = M_TOP;
         locked_d      = 1'b0;
         unlock_d      = 1'b0;
         rate_change_d = 1'b0;
         rx_rate_d     = rx_rate_q;
         rate_sel_d    = rate_sel_q;
      end
      serdes_rst_d = (state_d == S_RSTS) || (state_d == S_HOLD) || (state_d == S_INIT);
   end

   always_ff @(posedge rx_clk) begin
      if (!rstn) begin
         state_q       <= S_INIT;
         mode_q        <= M_TOP;
         cfg_q         <= '0;
         dwell_q       <= '0;
         lcnt_q        <= '0;
         rx_rate_q     <= 3'b000;
         rate_sel_q    <= 2'b00;
         serdes_rst_q  <= 1'b1;
         locked_q      <= 1'b0;
         rate_change_q <= 1'b0;
         unlock_q      <= 1'b0;
         scan_cnt_q    <= 8'd0;
      end else begin
         state_q       <= state_d;
         mode_q        <= mode_d;
         cfg_q         <= cfg;
         dwell_q       <= dwell_d;
         lcnt_q        <= lcnt_d;
         rx_rate_q     <= rx_rate_d;
         rate_sel_q    <= rate_sel_d;
         serdes_rst_q  <= serdes_rst_d;
         locked_q      <= locked_d;
         rate_change_q <= rate_change_d;
         unlock_q      <= unlock_d;
         scan_cnt_q    <= scan_cnt_d;
      end
   end

   assign bus.rx_rate         = rx_rate_q;
   assign bus.serdes_rate_sel = rate_sel_q;
   assign bus.serdes_rst      = serdes_rst_q;
   assign bus.locked          = locked_q;
   assign bus.rate_change     = rate_change_q;
   assign bus.unlock_evt      = unlock_q;
   assign bus.scan_cnt        = scan_cnt_q;
   assign bus.state_dbg       = state_q;

endmodule

// File: tb/tb_sdi_rx_scan_ctrl.sv
// Bench for sdi_rx_scan_ctrl: directed vector table with hand-computed expectations,
// plus hand-written scan-timing and mid-operation reset sequences.
module tb_sdi_rx_scan_ctrl;

   logic rx_clk = 1'b0;
   logic rstn   = 1'b0;
   int   checks = 0;
   int   errors = 0;

   sdi_rx_scan_ctrl_if bus();

   sdi_rx_scan_ctrl #(
      .pcntwidth(20), .pdwell_cycles(100), .prst_cycles(4),
      .plock_cycles(8), .ploss_cycles(16)
   ) dut (
      .rx_clk(rx_clk),
      .rstn  (rstn),
      .bus   (bus)
   );

   // Clock and reset
   always #5 rx_clk = ~rx_clk;

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   typedef struct {
      bit         rst;
      int         adv;
      logic [2:0] mask;
      logic       fen;
      logic [2:0] frate;
      logic       vid, tg, hd;
      logic [2:0] e_rx;
      logic [1:0] e_sel;
      logic       e_srst, e_lk, e_rc, e_ue;
      logic [7:0] e_sc;
   } vec_t;

   vec_t       tbl[$];
   logic [2:0] exp_q[$];
   int         gap_q[$];

   task automatic add(input bit rst, input int adv, input logic [2:0] mask, input logic fen,
                      input logic [2:0] frate, input logic vid, input logic tg, input logic hd,
                      input logic [2:0] e_rx, input logic [1:0] e_sel, input logic e_srst,
                      input logic e_lk, input logic e_rc, input logic e_ue, input logic [7:0] e_sc);
      vec_t v;
      v.rst = rst; v.adv = adv; v.mask = mask; v.fen = fen; v.frate = frate;
      v.vid = vid; v.tg = tg; v.hd = hd; v.e_rx = e_rx; v.e_sel = e_sel;
      v.e_srst = e_srst; v.e_lk = e_lk; v.e_rc = e_rc; v.e_ue = e_ue; v.e_sc = e_sc;
      tbl.push_back(v);
   endtask

   // Driver tasks
   task automatic set_in(input logic [2:0] mask, input logic fen, input logic [2:0] frate,
                         input logic vid, input logic tg, input logic hd);
      bus.scan_mask  = mask;
      bus.force_en   = fen;
      bus.force_rate = frate;
      bus.vid_active = vid;
      bus.rx_tg_hdn  = tg;
      bus.rx_hd_sdn  = hd;
   endtask

   task automatic do_reset();
      rstn = 1'b0;
      repeat (2) @(negedge rx_clk);
      rstn = 1'b1;
   endtask

   task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s[%0d]: got %0h expected %0h", name, idx, act, exp);
      end
   endtask

   task automatic wait_rc(input int max, output int n);
      n = 0;
      do begin
         @(negedge rx_clk);
         n++;
      end while (!bus.rate_change && n < max);
   endtask

   task automatic chk_reset_vals(input int idx);
      chk("rst_rx_rate", idx, 32'(bus.rx_rate), 32'd0);
      chk("rst_rate_sel", idx, 32'(bus.serdes_rate_sel), 32'd0);
      chk("rst_serdes_rst", idx, 32'(bus.serdes_rst), 32'd1);
      chk("rst_locked", idx, 32'(bus.locked), 32'd0);
      chk("rst_rate_change", idx, 32'(bus.rate_change), 32'd0);
      chk("rst_unlock_evt", idx, 32'(bus.unlock_evt), 32'd0);
      chk("rst_scan_cnt", idx, 32'(bus.scan_cnt), 32'd0);
      chk("rst_state", idx, 32'(bus.state_dbg), 32'd0);
   endtask

   initial begin
      int n;
      int g;
      logic [2:0] er;
      vec_t v;

      // Vector table: rst, adv, mask, fen, frate, vid, tg, hd | rx, sel, srst, lk, rc, ue, sc
      // Lock at HD after a 3G timeout, then loss supervision
      add(1,   2, 3'b111, 0, 3'b000, 1, 0, 1, 3'b100, 2'b10, 1, 0, 1, 0, 8'd0);
      add(0, 101, 3'b111, 0, 3'b000, 1, 0, 1, 3'b010, 2'b01, 1, 0, 1, 0, 8'd1);
      add(0,  11, 3'b111, 0, 3'b000, 1, 0, 1, 3'b010, 2'b01, 0, 0, 0, 0, 8'd1);
      add(0,   1, 3'b111, 0, 3'b000, 1, 0, 1, 3'b010, 2'b01, 0, 1, 0, 0, 8'd0);
      add(0,  50, 3'b111, 0, 3'b000, 1, 0, 1, 3'b010, 2'b01, 0, 1, 0, 0, 8'd0);
      add(0,  15, 3'b111, 0, 3'b000, 0, 0, 1, 3'b010, 2'b01, 0, 1, 0, 0, 8'd0);
      add(0,   1, 3'b111, 0, 3'b000, 1, 0, 1, 3'b010, 2'b01, 0, 1, 0, 0, 8'd0);
      add(0,  16, 3'b111, 0, 3'b000, 0, 0, 1, 3'b010, 2'b01, 0, 0, 0, 1, 8'd0);
      add(0,   1, 3'b111, 0, 3'b000, 0, 0, 1, 3'b010, 2'b01, 1, 0, 1, 0, 8'd0);
      // Lock at 3G, mask edit to SD, then empty mask
      add(1,   2, 3'b111, 0, 3'b000, 1, 1, 0, 3'b100, 2'b10, 1, 0, 1, 0, 8'd0);
      add(0,  11, 3'b111, 0, 3'b000, 1, 1, 0, 3'b100, 2'b10, 0, 0, 0, 0, 8'd0);
      add(0,   1, 3'b111, 0, 3'b000, 1, 1, 0, 3'b100, 2'b10, 0, 1, 0, 0, 8'd0);
      add(0,   6, 3'b111, 0, 3'b000, 1, 1, 0, 3'b100, 2'b10, 0, 1, 0, 0, 8'd0);
      add(0,   1, 3'b001, 0, 3'b000, 1, 1, 0, 3'b100, 2'b10, 0, 0, 0, 0, 8'd0);
      add(0,   1, 3'b001, 0, 3'b000, 1, 1, 0, 3'b001, 2'b00, 1, 0, 1, 0, 8'd0);
      add(0,   2, 3'b000, 0, 3'b000, 1, 1, 0, 3'b000, 2'b00, 1, 0, 0, 0, 8'd0);
      add(0,   5, 3'b000, 0, 3'b000, 1, 1, 0, 3'b000, 2'b00, 1, 0, 0, 0, 8'd0);
      // Forced SD without video, then an invalid forced rate
      add(1,   2, 3'b111, 1, 3'b001, 0, 0, 0, 3'b001, 2'b00, 1, 0, 1, 0, 8'd0);
      add(0, 101, 3'b111, 1, 3'b001, 0, 0, 0, 3'b001, 2'b00, 1, 0, 1, 0, 8'd1);
      add(0, 101, 3'b111, 1, 3'b001, 0, 0, 0, 3'b001, 2'b00, 1, 0, 1, 0, 8'd2);
      add(0,   6, 3'b111, 1, 3'b001, 0, 0, 0, 3'b001, 2'b00, 0, 0, 0, 0, 8'd2);
      add(0,   2, 3'b111, 1, 3'b011, 0, 0, 0, 3'b000, 2'b00, 1, 0, 0, 0, 8'd2);

      // Reset state
      set_in(3'b000, 1'b0, 3'b000, 1'b0, 1'b0, 1'b0);
      rstn = 1'b0;
      repeat (3) @(negedge rx_clk);
      chk_reset_vals(0);

      // Free scan with no video: rate order, spacing, SERDES reset width, timeout count
      exp_q = '{3'b100, 3'b010, 3'b001, 3'b100};
      gap_q = '{2, 97, 101, 101};
      set_in(3'b111, 1'b0, 3'b000, 1'b0, 1'b0, 1'b0);
      do_reset();
      for (int k = 0; k < 4; k++) begin
         g = gap_q.pop_front();
         wait_rc(g + 5, n);
         chk("scan_gap", k, 32'(n), 32'(g));
         er = exp_q.pop_front();
         chk("scan_rx_rate", k, 32'(bus.rx_rate), 32'(er));
         if (k == 0) begin
            chk("scan_srst", 0, 32'(bus.serdes_rst), 32'd1);
            for (int j = 1; j < 4; j++) begin
               @(negedge rx_clk);
               chk("scan_srst", j, 32'(bus.serdes_rst), 32'd1);
            end
            @(negedge rx_clk);
            chk("scan_srst", 4, 32'(bus.serdes_rst), 32'd0);
         end
      end
      chk("scan_cnt", 3, 32'(bus.scan_cnt), 32'd3);
      chk("scan_locked", 3, 32'(bus.locked), 32'd0);

      // Table-driven vectors
      for (int i = 0; i < tbl.size(); i++) begin
         v = tbl[i];
         set_in(v.mask, v.fen, v.frate, v.vid, v.tg, v.hd);
         if (v.rst) do_reset();
         repeat (v.adv) @(negedge rx_clk);
         chk("rx_rate", i, 32'(bus.rx_rate), 32'(v.e_rx));
         chk("rate_sel", i, 32'(bus.serdes_rate_sel), 32'(v.e_sel));
         chk("serdes_rst", i, 32'(bus.serdes_rst), 32'(v.e_srst));
         chk("locked", i, 32'(bus.locked), 32'(v.e_lk));
         chk("rate_change", i, 32'(bus.rate_change), 32'(v.e_rc));
         chk("unlock_evt", i, 32'(bus.unlock_evt), 32'(v.e_ue));
         chk("scan_cnt", i, 32'(bus.scan_cnt), 32'(v.e_sc));
      end

      // One-cycle reset while in the SERDES reset phase
      set_in(3'b111, 1'b0, 3'b000, 1'b0, 1'b0, 1'b0);
      do_reset();
      wait_rc(7, n);
      chk("mid_first_rc", 0, 32'(n), 32'd2);
      @(negedge rx_clk);
      rstn = 1'b0;
      @(negedge rx_clk);
      chk_reset_vals(1);
      rstn = 1'b1;
      wait_rc(7, n);
      chk("mid_rc_latency", 1, 32'(n), 32'd2);
      chk("mid_rx_rate", 1, 32'(bus.rx_rate), 32'(3'b100));

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
